// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for fp_divider.
// master drives operands and out_ready; slave is the divider.
interface fp_divider_if;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_z;
    logic        div_by_zero;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output input_a, input_b, in_valid, out_ready,
        input  in_ready, output_z, div_by_zero, out_valid
    );

    modport slave (
        input  input_a, input_b, in_valid, out_ready,
        output in_ready, output_z, div_by_zero, out_valid
    );
endinterface

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider, restoring radix-2, one quotient bit per cycle.
// Define FP_DIV_SUBNORMAL_EN for subnormal inputs and gradual underflow; otherwise subnormals flush to zero.
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    fp_divider_if.slave bus
);
    // state    | meaning
    // IDLE     | in_ready high, waiting for operands
    // UNPACK   | classify operands, resolve special cases
    // NORM     | normalize mantissas, form exponent difference
    // DIVIDE   | 27 restoring iterations
    // POSTNORM | align quotient, extract guard/round/sticky, denormalize
    // ROUND    | round to nearest even
    // PACK     | assemble result, raise out_valid
    // OUT      | hold result until out_ready
    typedef enum logic [2:0] {IDLE, UNPACK, NORM, DIVIDE, POSTNORM, ROUND, PACK, OUT} state_t;

    localparam logic signed [9:0] E_MIN     = -10'sd126;
    localparam logic signed [9:0] E_MAX     = 10'sd127;
    localparam logic [31:0]       CANON_NAN = 32'hFFC00000;

    state_t            state;
    logic [31:0]       a_r, b_r, special_z, output_z_r;
    logic              z_s, special, dbz_r, dbz_out, in_ready_r, out_valid_r;
    logic [23:0]       ma, mb, m;
    logic signed [9:0] ea, eb, e;
    logic [26:0]       q;
    logic [25:0]       rem;
    logic [4:0]        cnt;
    logic              guard_b, round_b, sticky_b;

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.output_z    = output_z_r;
    assign bus.div_by_zero = dbz_out;

    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_man, b_man;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special, zs_c;

    assign a_exp = a_r[30:23];
    assign b_exp = b_r[30:23];
    assign a_man = a_r[22:0];
    assign b_man = b_r[22:0];
    assign zs_c  = a_r[31] ^ b_r[31];
`ifdef FP_DIV_SUBNORMAL_EN
    assign a_zero = (a_exp == 8'd0) && (a_man == 23'd0);
    assign b_zero = (b_exp == 8'd0) && (b_man == 23'd0);
`else
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);
`endif
    assign a_inf = (a_exp == 8'hFF) && (a_man == 23'd0);
    assign b_inf = (b_exp == 8'hFF) && (b_man == 23'd0);
    assign a_nan = (a_exp == 8'hFF) && (a_man != 23'd0);
    assign b_nan = (b_exp == 8'hFF) && (b_man != 23'd0);
    assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    logic [23:0]       ma_n, mb_n;
    logic signed [9:0] ea_n, eb_n;
`ifdef FP_DIV_SUBNORMAL_EN
    function automatic logic [4:0] lead_zeros(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++)
            if (v[i]) n = 5'(23 - i);
        return n;
    endfunction

    logic [4:0] sh_a, sh_b;
    always_comb begin
        sh_a = lead_zeros(ma);
        sh_b = lead_zeros(mb);
        ma_n = ma << sh_a;
        mb_n = mb << sh_b;
        ea_n = ea - 10'(sh_a);
        eb_n = eb - 10'(sh_b);
    end
`else
    assign ma_n = ma;
    assign mb_n = mb;
    assign ea_n = ea;
    assign eb_n = eb;
`endif

    logic              rem_ge;
    assign rem_ge = (rem >= {2'b00, mb});

    // pv packs {mantissa, guard, round, sticky} so the denormal shift can fold lost bits into sticky
    logic [26:0]       qn, pv, pv_sh;
    logic signed [9:0] pe;
`ifdef FP_DIV_SUBNORMAL_EN
    logic signed [9:0] pe_d;
    logic [4:0]        psh;
    logic [26:0]       pmask;
    logic              plost;
`endif
    always_comb begin
        qn    = q[26] ? q : {q[25:0], 1'b0};
        pe    = q[26] ? e : e - 10'sd1;
        pv    = {qn[26:1], qn[0] | (rem != 26'd0)};
        pv_sh = pv;
`ifdef FP_DIV_SUBNORMAL_EN
        pe_d  = 10'sd0;
        psh   = 5'd0;
        pmask = 27'd0;
        plost = 1'b0;
        if (pe < E_MIN) begin
            pe_d  = E_MIN - pe;
            psh   = (pe_d > 10'sd27) ? 5'd27 : pe_d[4:0];
            pmask = (27'd1 << psh) - 27'd1;
            plost = |(pv & pmask);
            pv_sh = (pv >> psh) | {26'd0, plost};
            pe    = E_MIN;
        end
`endif
    end

    logic [24:0] m_sum;
    logic [7:0]  exp_field;
    assign m_sum     = {1'b0, m} + {24'd0, guard_b & (round_b | sticky_b | m[0])};
    assign exp_field = e[7:0] + 8'd127;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            special_z   <= '0;
            output_z_r  <= '0;
            z_s         <= 1'b0;
            special     <= 1'b0;
            dbz_r       <= 1'b0;
            dbz_out     <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            m           <= '0;
            ea          <= '0;
            eb          <= '0;
            e           <= '0;
            q           <= '0;
            rem         <= '0;
            cnt         <= '0;
            guard_b     <= 1'b0;
            round_b     <= 1'b0;
            sticky_b    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.input_a;
                        b_r        <= bus.input_b;
                        in_ready_r <= 1'b0;
                        state      <= UNPACK;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                UNPACK: begin
                    z_s     <= zs_c;
                    ma      <= {a_exp != 8'd0, a_man};
                    mb      <= {b_exp != 8'd0, b_man};
                    ea      <= (a_exp == 8'd0) ? E_MIN : {2'b00, a_exp} - 10'd127;
                    eb      <= (b_exp == 8'd0) ? E_MIN : {2'b00, b_exp} - 10'd127;
                    special <= is_special;
                    dbz_r   <= 1'b0;
                    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                        special_z <= CANON_NAN;
                    end else if (a_inf | b_zero) begin
                        special_z <= {zs_c, 8'hFF, 23'd0};
                        dbz_r     <= b_zero & ~a_inf;
                    end else begin
                        special_z <= {zs_c, 31'd0};
                    end
                    state <= is_special ? PACK : NORM;
                end
                NORM: begin
                    rem   <= {2'b00, ma_n};
                    mb    <= mb_n;
                    e     <= ea_n - eb_n;
                    q     <= '0;
                    cnt   <= '0;
                    state <= DIVIDE;
                end
                DIVIDE: begin
                    rem <= (rem_ge ? rem - {2'b00, mb} : rem) << 1;
                    q   <= {q[25:0], rem_ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd26) state <= POSTNORM;
                end
                POSTNORM: begin
                    m        <= pv_sh[26:3];
                    guard_b  <= pv_sh[2];
                    round_b  <= pv_sh[1];
                    sticky_b <= pv_sh[0];
                    e        <= pe;
                    state    <= ROUND;
                end
                ROUND: begin
                    if (m_sum[24]) begin
                        m <= 24'h800000;
                        e <= e + 10'sd1;
                    end else begin
                        m <= m_sum[23:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    out_valid_r <= 1'b1;
                    dbz_out     <= special & dbz_r;
                    if (special)
                        output_z_r <= special_z;
                    else if (e > E_MAX)
                        output_z_r <= {z_s, 8'hFF, 23'd0};
                    else if (e < E_MIN)
                        output_z_r <= {z_s, 31'd0};
                    else if (!m[23])
                        output_z_r <= {z_s, 8'd0, m[22:0]};
                    else
                        output_z_r <= {z_s, exp_field, m[22:0]};
                    state <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_divider.sv
// Directed scoreboard bench for fp_divider: latency, rounding, specials, backpressure, mid-operation reset.
module tb_fp_divider;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] sb_z[$];
    logic        sb_d[$];

    fp_divider_if bus();

    fp_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one operation; in_valid stays high with random operands while busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ez, input logic edz, input int lat);
        int          k;
        logic        ready_seen;
        logic [31:0] want_z;
        logic        want_d;
        sb_z.push_back(ez);
        sb_d.push_back(edz);
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready_wait"}, 32'(k < 100), 32'd1);
        bus.input_a  = a;
        bus.input_b  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.input_a = $urandom;
        bus.input_b = $urandom;
        ready_seen  = 1'b0;
        k = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && k < 100) begin
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " in_ready_busy"}, 32'(ready_seen), 32'd0);
        want_z = sb_z.pop_front();
        want_d = sb_d.pop_front();
        check({tag, " z"}, bus.output_z, want_z);
        check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(want_d));
        if (bus.out_ready === 1'b1) begin
            @(negedge clk);
            check({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
            check({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        int   k;
        logic ok;

        rst           = 1'b0;
        bus.input_a   = '0;
        bus.input_b   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst output_z", bus.output_z, 32'd0);
        check("rst dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rel in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("rel in_ready_after_edge", 32'(bus.in_ready), 32'd1);

        run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 32);
        run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 32);
        run_op("-1/3",     32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0, 32);
        run_op("3/1",      32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, 32);
        run_op("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
        run_op("0/0",      32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0, 2);
        run_op("inf/inf",  32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0, 2);
        run_op("nan/1",    32'h7FC00001, 32'h3F800000, 32'hFFC00000, 1'b0, 2);
        run_op("inf/1",    32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 2);
        run_op("0/-2",     32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 2);
        run_op("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 32);
`ifdef FP_DIV_SUBNORMAL_EN
        run_op("underflow", 32'h00800000, 32'h40000000, 32'h00400000, 1'b0, 32);
`else
        run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 32);
`endif

        bus.out_ready = 1'b0;
        run_op("bp 1/4", 32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, 32);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.output_z !== 32'h3E800000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                ok = 1'b0;
        end
        check("bp hold", 32'(ok), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("bp in_ready_back", 32'(bus.in_ready), 32'd1);
        run_op("bp 10/5", 32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, 32);

        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("midrst in_ready_wait", 32'(k < 100), 32'd1);
        bus.input_a  = 32'h40C00000;
        bus.input_b  = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst output_z", bus.output_z, 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ok = 1'b0;
        end
        check("midrst no_result", 32'(ok), 32'd1);
        run_op("after_rst 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 32);

        check("scoreboard empty", 32'(sb_z.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
